// File: rtl/mem_rr_access_scheduler_if.sv
// Requester-side and SRAM-side bus of the round-robin memory access scheduler.
// The scheduler attaches through the slave modport; requesters and the SRAM model use master.
interface mem_rr_access_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [2:0]          req;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          ack;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [2:0]          grant;
  logic                busy;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output ack, rvalid, rdata, grant, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  ack, rvalid, rdata, grant, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_rr_access_scheduler.sv
// Round-robin scheduler sharing one single-port synchronous SRAM between three requesters.
// One access at a time: IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> DONE.
module mem_rr_access_scheduler #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input logic                         clk,
  input logic                         reset,
  mem_rr_access_scheduler_if.slave    sched_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        owner_oh_s;

  // Priority starts at the requester after the last one served.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] p0, p1, p2;
    case (last)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (r[p0]) begin
      return p0;
    end else if (r[p1]) begin
      return p1;
    end else begin
      return p2;
    end
  endfunction

  // State and latched-access registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitration only happens in IDLE, the owner is frozen afterwards.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|sched_if.req) begin
          owner_d = rr_pick(sched_if.req, last_q);
          we_d    = sched_if.req_we[owner_d];
          addr_d  = sched_if.req_addr[32'(owner_d) * ADDR_W +: ADDR_W];
          wdata_d = sched_if.req_wdata[32'(owner_d) * DATA_W +: DATA_W];
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Last wait cycle is exactly RD_LAT cycles after the strobe: data is valid now.
        if (cnt_q == 3'd1) begin
          rdata_d = sched_if.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          state_d = WAIT;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    owner_oh_s         = 3'b001 << owner_q;
    sched_if.grant     = 3'b000;
    sched_if.ack       = 3'b000;
    sched_if.rvalid    = 3'b000;
    sched_if.mem_en    = 1'b0;
    sched_if.mem_we    = 1'b0;
    sched_if.busy      = (state_q != IDLE);
    sched_if.mem_addr  = addr_q;
    sched_if.mem_wdata = wdata_q;
    sched_if.rdata     = rdata_q;
    case (state_q)
      ISSUE: begin
        sched_if.grant  = owner_oh_s;
        sched_if.mem_en = 1'b1;
        sched_if.mem_we = we_q;
      end
      WAIT: begin
        sched_if.grant = owner_oh_s;
      end
      DONE: begin
        sched_if.grant  = owner_oh_s;
        sched_if.ack    = owner_oh_s;
        sched_if.rvalid = we_q ? 3'b000 : owner_oh_s;
      end
      default: begin
        sched_if.grant = 3'b000;
      end
    endcase
  end

endmodule

// File: doc/mem_rr_access_scheduler.md
Name: mem_rr_access_scheduler

Overview:
Shares one single-port synchronous SRAM between three requesters. It uses round-robin arbitration and a sequencing FSM. A winning request is latched, issued to the SRAM for exactly one cycle, and waited on for the read latency if it is a read. The requester is then completed with a one-cycle ack, plus read data for reads. It sits between the requester ports and the memory macro, and it holds the grant for the entire access.

Parameters:
ADDR_W, 8, SRAM address width
DATA_W, 8, SRAM data width
RD_LAT, 2, SRAM read latency in cycles (mem_en cycle to mem_rdata valid); legal range 1..7

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  3  per-requester request level
req_we  in  3  per-requester write enable (1 = write, 0 = read)
req_addr  in  3*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
req_wdata  in  3*DATA_W  requester i write data at [i*DATA_W +: DATA_W]
ack  out  3  one-hot one-cycle completion pulse
rvalid  out  3  one-hot one-cycle read-data-valid pulse, coincident with ack, reads only
rdata  out  DATA_W  read data for the completing read
grant  out  3  one-hot current owner, held from ISSUE through DONE
busy  out  1  high whenever state is not IDLE
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after mem_en

Behaviour:
- Reset values (async, active-high):
  - state = IDLE; last_owner = 2, so the first priority order is 0>1>2.
  - ack, rvalid, grant, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - busy = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from req to any output.
- IDLE:
  - If any req is high, pick the winner using round-robin order starting after last_owner:
    - last_owner 0 gives 1>2>0.
    - last_owner 1 gives 2>0>1.
    - last_owner 2 gives 0>1>2.
  - Latch the winner index, its we, addr and wdata, then go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata equal the latched values; grant = onehot(owner).
  - On a write, go to DONE. On a read, go to WAIT and load the counter with RD_LAT.
- WAIT (exactly RD_LAT cycles):
  - mem_en = 0 and mem_we = 0; mem_addr is held.
  - In the last WAIT cycle (the cycle RD_LAT after ISSUE), capture mem_rdata into rdata, then go to DONE.
- DONE (1 cycle):
  - ack[owner] = 1.
  - If the access was a read, rvalid[owner] = 1 and rdata is valid.
  - Update last_owner = owner, then go to IDLE. grant clears on exit.
- rdata holds its last captured value until the next read capture. Writes never change rdata.
- Latency, counted from the IDLE cycle in which req is sampled (cycle 0):
  - Write: ISSUE at cycle 1, ack at cycle 2.
  - Read: ISSUE at cycle 1, ack/rvalid at cycle 2+RD_LAT.
  - Minimum spacing between back-to-back accesses: 3 cycles for writes, 3+RD_LAT cycles for reads.
- Handshake:
  - A requester holds req high until it sees ack, then deasserts req at the next edge.
  - req high during IDLE is always a new request.
  - req, addr, wdata and we changes after latching are ignored until DONE.
- Simultaneous requests are resolved only in IDLE. Requests that lose arbitration stay pending and are served in later rotations; with all three requesting continuously, service order is strictly 0,1,2,0,...
- A req that drops while unserved is silently dropped. A req that drops while owned still completes, and its ack is still pulsed.
- Reset mid-operation:
  - The FSM returns to IDLE and the in-flight access is abandoned with no ack.
  - A write already strobed is not retracted.
  - last_owner returns to 2.
- Out-of-range RD_LAT (0 or >7) is a configuration error and is not supported.

Test Plan:
- Single write: req=001, we=1, addr=0x10, wdata=0xA5 → mem_en/mem_we high with addr 0x10/data 0xA5 in cycle 1; ack=001 in cycle 2; rvalid=000.
- Single read, RD_LAT=2: req=010, addr=0x10, SRAM model returns 0xA5 → mem_en cycle 1 with mem_we=0; rdata=0xA5 with ack=rvalid=010 in cycle 4.
- Fairness: req=111 held, each requester drops req after its ack and re-raises it → grant sequence 001,010,100,001,... and no requester served twice before the others.
- Rotation after idle: serve requester 1 alone, then assert req=111 → next grant=100, then 001.
- Ownership hold: requester 0 owns a read; req[2] rises during WAIT → requester 2 is not issued until DONE; next ISSUE is for requester 2.
- Reset mid-read: assert reset in a WAIT cycle → ack, rvalid, grant, busy and mem_en are 0 immediately; after release with req=111, first grant=001.
